// File: rtl/controlador_ascensor.sv
// SCAN-style motion controller for the 4-floor car: idles, travels floor by floor,
// and holds the door open while emitting the clear mask for the request registrador.
module controlador_ascensor #(
   parameter int T_VIAJE  = 8,
   parameter int T_PUERTA = 5
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [9:0] pedidos,
   output logic [9:0] atendidos,
   output logic [1:0] piso,
   output logic       subiendo,
   output logic       motor_on,
   output logic       puerta_abierta
);

   localparam int T_MAX = (T_VIAJE > T_PUERTA) ? T_VIAJE : T_PUERTA;
   localparam int TW    = $clog2(T_MAX + 1);

   typedef enum logic [1:0] {REPOSO, MOVIENDO, PUERTA} estado_t;

   estado_t       estado;
   logic [TW-1:0] timer;

   function automatic logic [9:0] up_hall(input logic [1:0] f);
      case (f)
         2'd0:    return 10'b00_0000_0001;
         2'd1:    return 10'b00_0000_0100;
         2'd2:    return 10'b00_0001_0000;
         default: return 10'b00_0000_0000;
      endcase
   endfunction

   function automatic logic [9:0] down_hall(input logic [1:0] f);
      case (f)
         2'd1:    return 10'b00_0000_0010;
         2'd2:    return 10'b00_0000_1000;
         2'd3:    return 10'b00_0010_0000;
         default: return 10'b00_0000_0000;
      endcase
   endfunction

   function automatic logic [9:0] cabin(input logic [1:0] f);
      return 10'b00_0100_0000 << f;
   endfunction

   function automatic logic [9:0] floor_mask(input logic [1:0] f);
      return up_hall(f) | down_hall(f) | cabin(f);
   endfunction

   function automatic logic [9:0] mask_above(input logic [1:0] f);
      logic [9:0] m;
      m = '0;
      for (int g = 0; g < 4; g++)
         if (g > int'(f)) m = m | floor_mask(2'(g));
      return m;
   endfunction

   function automatic logic [9:0] mask_below(input logic [1:0] f);
      logic [9:0] m;
      m = '0;
      for (int g = 0; g < 4; g++)
         if (g < int'(f)) m = m | floor_mask(2'(g));
      return m;
   endfunction

   logic [1:0] next_piso;
   logic       here_req;
   logic       same_here;
   logic       ahead_cur;
   logic       behind_cur;
   logic [1:0] stop_floor;
   logic       stop_dir;
   logic       stop_ahead;
   logic       stop_same;
   logic [9:0] stop_mask;
   logic       stop_sub;

   // The "stop" terms describe the floor where the door would open: the current floor
   // when idle, or the floor being reached when travelling.
   always_comb begin
      next_piso = piso;
      if (subiendo && piso != 2'd3)
         next_piso = piso + 2'd1;
      else if (!subiendo && piso != 2'd0)
         next_piso = piso - 2'd1;

      here_req   = |(pedidos & floor_mask(piso));
      same_here  = subiendo ? |(pedidos & (up_hall(piso) | cabin(piso)))
                            : |(pedidos & (down_hall(piso) | cabin(piso)));
      ahead_cur  = subiendo ? |(pedidos & mask_above(piso)) : |(pedidos & mask_below(piso));
      behind_cur = subiendo ? |(pedidos & mask_below(piso)) : |(pedidos & mask_above(piso));

      stop_floor = (estado == MOVIENDO) ? next_piso : piso;
      stop_dir   = (estado == MOVIENDO) ? subiendo : (same_here ? subiendo : ~subiendo);
      stop_ahead = stop_dir ? |(pedidos & mask_above(stop_floor))
                            : |(pedidos & mask_below(stop_floor));
      stop_same  = stop_dir ? |(pedidos & (up_hall(stop_floor) | cabin(stop_floor)))
                            : |(pedidos & (down_hall(stop_floor) | cabin(stop_floor)));

      stop_mask = cabin(stop_floor) | (stop_dir ? up_hall(stop_floor) : down_hall(stop_floor));
      if (!stop_ahead)
         stop_mask = stop_mask | (pedidos & (stop_dir ? down_hall(stop_floor) : up_hall(stop_floor)));
      stop_sub = stop_ahead ? stop_dir : ~stop_dir;
   end

   // Single state register; atendidos is a held mask for the whole door period so a
   // fresh matching press is cleared immediately without touching the door timer.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         estado         <= REPOSO;
         piso           <= 2'd0;
         subiendo       <= 1'b1;
         motor_on       <= 1'b0;
         puerta_abierta <= 1'b0;
         atendidos      <= '0;
         timer          <= '0;
      end else begin
         case (estado)
            REPOSO: begin
               timer <= '0;
               if (here_req) begin
                  estado         <= PUERTA;
                  puerta_abierta <= 1'b1;
                  atendidos      <= stop_mask;
                  subiendo       <= stop_sub;
               end else if (ahead_cur) begin
                  estado   <= MOVIENDO;
                  motor_on <= 1'b1;
               end else if (behind_cur) begin
                  estado   <= MOVIENDO;
                  motor_on <= 1'b1;
                  subiendo <= ~subiendo;
               end
            end
            MOVIENDO: begin
               if (timer == TW'(T_VIAJE - 1)) begin
                  timer <= '0;
                  piso  <= next_piso;
                  if (stop_same || !stop_ahead) begin
                     estado         <= PUERTA;
                     motor_on       <= 1'b0;
                     puerta_abierta <= 1'b1;
                     atendidos      <= stop_mask;
                     subiendo       <= stop_sub;
                  end
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            PUERTA: begin
               if (timer == TW'(T_PUERTA - 1)) begin
                  timer          <= '0;
                  estado         <= REPOSO;
                  puerta_abierta <= 1'b0;
                  atendidos      <= '0;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            default: estado <= REPOSO;
         endcase
      end
   end

endmodule
